// File: rtl/mips_ctrl_pkg.sv
// Shared opcode, ALU-code and control-word definitions for the MIPS pipeline control unit.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int ALU_CODE_W = 3;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALU_CODE_W-1:0] ALU_FUNCT = 3'b010;
    localparam logic [ALU_CODE_W-1:0] ALU_AND   = 3'b011;
    localparam logic [ALU_CODE_W-1:0] ALU_OR    = 3'b100;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT   = 3'b101;
    localparam logic [ALU_CODE_W-1:0] ALU_LUI   = 3'b110;

    // Jump is resolved in ID, so it is not part of the word carried down the pipe.
    typedef struct packed {
        logic                  reg_write;
        logic                  reg_dst;
        logic                  alu_src;
        logic                  branch_beq;
        logic                  branch_bne;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  link;
        logic [ALU_CODE_W-1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic link;
    } mem_ctrl_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        logic link;
    } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main decoder: ID opcode to control word, jump and illegal flags.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op_id,
    input  logic       valid_id,
    output ctrl_t      ctrl,
    output logic       jump,
    output logic       illegal
);

    logic undefined;

    always_comb begin
        ctrl      = '0;
        jump      = 1'b0;
        undefined = 1'b0;
        unique case (op_id)
            OP_RTYPE: begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_FUNCT; end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            OP_SW:   begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; ctrl.alu_op = ALU_ADD; end
            OP_BEQ:  begin ctrl.branch_beq = 1'b1; ctrl.alu_op = ALU_SUB; end
            OP_BNE:  begin ctrl.branch_bne = 1'b1; ctrl.alu_op = ALU_SUB; end
            OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD; end
            OP_ANDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_AND; end
            OP_ORI:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_OR; end
            OP_SLTI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_SLT; end
            OP_LUI:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_LUI; end
            OP_J:    jump = 1'b1;
            // jal writes r31; the datapath selects PC+8 when link is set.
            OP_JAL:  begin jump = 1'b1; ctrl.reg_write = 1'b1; ctrl.link = 1'b1; end
            default: undefined = 1'b1;
        endcase
    end

    assign illegal = valid_id & undefined;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode plus ID/EX, EX/MEM and MEM/WB control registers,
// with bubble injection, squash, sticky illegal-opcode flag and a saturating bubble counter.
module pipe_ctrl_unit
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op_id,
    input  logic               valid_id,
    input  logic               stall_id,
    input  logic               kill_id,
    input  logic               kill_ex,
    output logic               jump_id,
    output logic               illegal_id,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_reg_dst,
    output logic               ex_alu_src,
    output logic               ex_branch_beq,
    output logic               ex_branch_bne,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_link,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               mem_valid,
    output logic               mem_reg_write,
    output logic               mem_mem_write,
    output logic               mem_mem_to_reg,
    output logic               mem_link,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic               wb_link,
    output logic               illegal_seen,
    output logic [CNT_W-1:0]   bubble_cnt
);

    ctrl_t      dec_ctrl;
    logic       dec_jump;
    ctrl_t      ex_ctrl;
    logic       ex_v;
    mem_ctrl_t  mem_q;
    wb_ctrl_t   wb_q;
    logic       ex_bubble;
    logic       illegal_accept;
    logic [CNT_W-1:0] cnt_q;

    ctrl_decode u_decode (
        .op_id    (op_id),
        .valid_id (valid_id),
        .ctrl     (dec_ctrl),
        .jump     (dec_jump),
        .illegal  (illegal_id)
    );

    assign jump_id        = valid_id & dec_jump;
    assign ex_bubble      = stall_id | kill_id | ~valid_id | illegal_id;
    assign illegal_accept = illegal_id & ~stall_id & ~kill_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl      <= '0;
            ex_v         <= 1'b0;
            mem_q        <= '0;
            wb_q         <= '0;
            illegal_seen <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (ex_bubble) begin
                ex_ctrl <= '0;
                ex_v    <= 1'b0;
            end else begin
                ex_ctrl <= dec_ctrl;
                ex_v    <= 1'b1;
            end

            if (kill_ex || !ex_v) begin
                mem_q <= '0;
            end else begin
                mem_q <= '{valid: 1'b1, reg_write: ex_ctrl.reg_write, mem_write: ex_ctrl.mem_write,
                           mem_to_reg: ex_ctrl.mem_to_reg, link: ex_ctrl.link};
            end

            wb_q <= '{valid: mem_q.valid, reg_write: mem_q.reg_write,
                      mem_to_reg: mem_q.mem_to_reg, link: mem_q.link};

            if (illegal_accept) illegal_seen <= 1'b1;

            // Saturate at all-ones rather than wrapping.
            if (ex_bubble && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ex_valid       = ex_v;
    assign ex_reg_write   = ex_ctrl.reg_write;
    assign ex_reg_dst     = ex_ctrl.reg_dst;
    assign ex_alu_src     = ex_ctrl.alu_src;
    assign ex_branch_beq  = ex_ctrl.branch_beq;
    assign ex_branch_bne  = ex_ctrl.branch_bne;
    assign ex_mem_write   = ex_ctrl.mem_write;
    assign ex_mem_to_reg  = ex_ctrl.mem_to_reg;
    assign ex_link        = ex_ctrl.link;
    assign ex_alu_op      = ALUOP_W'(ex_ctrl.alu_op);

    assign mem_valid      = mem_q.valid;
    assign mem_reg_write  = mem_q.reg_write;
    assign mem_mem_write  = mem_q.mem_write;
    assign mem_mem_to_reg = mem_q.mem_to_reg;
    assign mem_link       = mem_q.link;

    assign wb_valid       = wb_q.valid;
    assign wb_reg_write   = wb_q.reg_write;
    assign wb_mem_to_reg  = wb_q.mem_to_reg;
    assign wb_link        = wb_q.link;

    assign bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed, table-driven bench for pipe_ctrl_unit, with a second instance at CNT_W=2.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op_id;
    logic       valid_id, stall_id, kill_id, kill_ex;

    logic       jump_id, illegal_id;
    logic       ex_valid, ex_reg_write, ex_reg_dst, ex_alu_src, ex_branch_beq, ex_branch_bne;
    logic       ex_mem_write, ex_mem_to_reg, ex_link;
    logic [2:0] ex_alu_op;
    logic       mem_valid, mem_reg_write, mem_mem_write, mem_mem_to_reg, mem_link;
    logic       wb_valid, wb_reg_write, wb_mem_to_reg, wb_link;
    logic       illegal_seen;
    logic [7:0] bubble_cnt;

    logic       s_jump_id, s_illegal_id;
    logic       s_ex_valid, s_ex_reg_write, s_ex_reg_dst, s_ex_alu_src, s_ex_branch_beq, s_ex_branch_bne;
    logic       s_ex_mem_write, s_ex_mem_to_reg, s_ex_link;
    logic [2:0] s_ex_alu_op;
    logic       s_mem_valid, s_mem_reg_write, s_mem_mem_write, s_mem_mem_to_reg, s_mem_link;
    logic       s_wb_valid, s_wb_reg_write, s_wb_mem_to_reg, s_wb_link;
    logic       s_illegal_seen;
    logic [1:0] s_bubble_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.ALUOP_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .op_id(op_id), .valid_id(valid_id), .stall_id(stall_id),
        .kill_id(kill_id), .kill_ex(kill_ex), .jump_id(jump_id), .illegal_id(illegal_id),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_reg_dst(ex_reg_dst),
        .ex_alu_src(ex_alu_src), .ex_branch_beq(ex_branch_beq), .ex_branch_bne(ex_branch_bne),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_link(ex_link),
        .ex_alu_op(ex_alu_op), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_link(mem_link),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_link(wb_link), .illegal_seen(illegal_seen), .bubble_cnt(bubble_cnt)
    );

    pipe_ctrl_unit #(.ALUOP_W(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .op_id(op_id), .valid_id(valid_id), .stall_id(stall_id),
        .kill_id(kill_id), .kill_ex(kill_ex), .jump_id(s_jump_id), .illegal_id(s_illegal_id),
        .ex_valid(s_ex_valid), .ex_reg_write(s_ex_reg_write), .ex_reg_dst(s_ex_reg_dst),
        .ex_alu_src(s_ex_alu_src), .ex_branch_beq(s_ex_branch_beq), .ex_branch_bne(s_ex_branch_bne),
        .ex_mem_write(s_ex_mem_write), .ex_mem_to_reg(s_ex_mem_to_reg), .ex_link(s_ex_link),
        .ex_alu_op(s_ex_alu_op), .mem_valid(s_mem_valid), .mem_reg_write(s_mem_reg_write),
        .mem_mem_write(s_mem_mem_write), .mem_mem_to_reg(s_mem_mem_to_reg), .mem_link(s_mem_link),
        .wb_valid(s_wb_valid), .wb_reg_write(s_wb_reg_write), .wb_mem_to_reg(s_wb_mem_to_reg),
        .wb_link(s_wb_link), .illegal_seen(s_illegal_seen), .bubble_cnt(s_bubble_cnt)
    );

    // {valid, reg_write, reg_dst, alu_src, beq, bne, mem_write, mem_to_reg, link, alu_op[2:0]}
    typedef struct {
        logic [5:0]  op;
        logic        valid;
        logic        stall;
        logic        kill;
        logic [11:0] exp_ex;
        logic        exp_ill;
        logic        exp_jmp;
    } vec_t;

    localparam int NVEC = 68;
    vec_t vecs [NVEC];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [11:0] ex_word();
        return {ex_valid, ex_reg_write, ex_reg_dst, ex_alu_src, ex_branch_beq, ex_branch_bne,
                ex_mem_write, ex_mem_to_reg, ex_link, ex_alu_op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [5:0] op, input logic v, input logic st, input logic ki, input logic kx);
        op_id = op; valid_id = v; stall_id = st; kill_id = ki; kill_ex = kx;
    endtask

    task automatic set_legal(input int idx, input logic [11:0] w, input logic jmp);
        vecs[idx].exp_ex  = w;
        vecs[idx].exp_ill = 1'b0;
        vecs[idx].exp_jmp = jmp;
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            vecs[i] = '{op: 6'(i), valid: 1'b1, stall: 1'b0, kill: 1'b0,
                        exp_ex: 12'h000, exp_ill: 1'b1, exp_jmp: 1'b0};
        set_legal( 0, 12'b111000000010, 1'b0);  // R-type
        set_legal( 2, 12'b100000000000, 1'b1);  // j
        set_legal( 3, 12'b110000001000, 1'b1);  // jal
        set_legal( 4, 12'b100010000001, 1'b0);  // beq
        set_legal( 5, 12'b100001000001, 1'b0);  // bne
        set_legal( 8, 12'b110100000000, 1'b0);  // addi
        set_legal(10, 12'b110100000101, 1'b0);  // slti
        set_legal(12, 12'b110100000011, 1'b0);  // andi
        set_legal(13, 12'b110100000100, 1'b0);  // ori
        set_legal(15, 12'b110100000110, 1'b0);  // lui
        set_legal(35, 12'b110100010000, 1'b0);  // lw
        set_legal(43, 12'b100100100000, 1'b0);  // sw
        vecs[64] = '{op: 6'b100011, valid: 1'b0, stall: 1'b0, kill: 1'b0, exp_ex: 12'h000, exp_ill: 1'b0, exp_jmp: 1'b0};
        vecs[65] = '{op: 6'b100011, valid: 1'b1, stall: 1'b1, kill: 1'b0, exp_ex: 12'h000, exp_ill: 1'b0, exp_jmp: 1'b0};
        vecs[66] = '{op: 6'b000000, valid: 1'b1, stall: 1'b0, kill: 1'b1, exp_ex: 12'h000, exp_ill: 1'b0, exp_jmp: 1'b0};
        vecs[67] = '{op: 6'b000010, valid: 1'b0, stall: 1'b0, kill: 1'b0, exp_ex: 12'h000, exp_ill: 1'b0, exp_jmp: 1'b0};

        // Power-on reset with clock running
        rst_n = 1'b0;
        drive(6'b100011, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("rst ex_valid", 32'(ex_valid), 0);
        chk("rst mem_valid", 32'(mem_valid), 0);
        chk("rst wb_valid", 32'(wb_valid), 0);
        chk("rst ex_word", 32'(ex_word()), 0);
        chk("rst bubble_cnt", 32'(bubble_cnt), 0);
        chk("rst illegal_seen", 32'(illegal_seen), 0);

        // addi stalled for two cycles, released straight out of reset
        drive(6'b001000, 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("stall1 ex_valid", 32'(ex_valid), 0);
        chk("stall1 bubble_cnt", 32'(bubble_cnt), 1);
        tick();
        chk("stall2 ex_valid", 32'(ex_valid), 0);
        chk("stall2 bubble_cnt", 32'(bubble_cnt), 2);
        stall_id = 1'b0;
        tick();
        chk("stall3 ex_reg_write", 32'(ex_reg_write), 1);
        chk("stall3 ex_alu_op", 32'(ex_alu_op), 0);
        chk("stall3 ex_valid", 32'(ex_valid), 1);
        chk("stall3 bubble_cnt", 32'(bubble_cnt), 2);

        // Opcode sweep plus bubble-cause vectors
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].op, vecs[i].valid, vecs[i].stall, vecs[i].kill, 1'b0);
            #1;
            chk($sformatf("vec%0d op%0h illegal_id", i, vecs[i].op), 32'(illegal_id), 32'(vecs[i].exp_ill));
            chk($sformatf("vec%0d op%0h jump_id", i, vecs[i].op), 32'(jump_id), 32'(vecs[i].exp_jmp));
            tick();
            chk($sformatf("vec%0d op%0h ex_word", i, vecs[i].op), 32'(ex_word()), 32'(vecs[i].exp_ex));
        end
        chk("sweep illegal_seen", 32'(illegal_seen), 1);

        // lw in flight, reset asserted mid-cycle
        drive(6'b100011, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst ex_valid", 32'(ex_valid), 0);
        chk("midrst ex_mem_to_reg", 32'(ex_mem_to_reg), 0);
        chk("midrst mem_valid", 32'(mem_valid), 0);
        chk("midrst wb_valid", 32'(wb_valid), 0);
        chk("midrst bubble_cnt", 32'(bubble_cnt), 0);
        chk("midrst illegal_seen", 32'(illegal_seen), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post lw ex_mem_to_reg", 32'(ex_mem_to_reg), 1);
        chk("post lw ex_alu_src", 32'(ex_alu_src), 1);
        valid_id = 1'b0;
        tick();
        chk("post lw mem_mem_to_reg", 32'(mem_mem_to_reg), 1);
        tick();
        chk("post lw wb_mem_to_reg", 32'(wb_mem_to_reg), 1);
        chk("post lw wb_reg_write", 32'(wb_reg_write), 1);

        // Illegal opcodes that are stalled or killed do not set the sticky flag
        drive(6'b111111, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("ill stall illegal_id", 32'(illegal_id), 1);
        tick();
        chk("ill stall illegal_seen", 32'(illegal_seen), 0);
        drive(6'b111111, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("ill kill illegal_seen", 32'(illegal_seen), 0);
        drive(6'b111111, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ill accept illegal_seen", 32'(illegal_seen), 1);
        drive(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ill sticky illegal_seen", 32'(illegal_seen), 1);

        // jal through the pipe
        drive(6'b000011, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("jal jump_id", 32'(jump_id), 1);
        tick();
        chk("jal ex_link", 32'(ex_link), 1);
        chk("jal ex_reg_write", 32'(ex_reg_write), 1);
        valid_id = 1'b0;
        tick();
        chk("jal mem_link", 32'(mem_link), 1);
        tick();
        chk("jal wb_link", 32'(wb_link), 1);
        chk("jal wb_reg_write", 32'(wb_reg_write), 1);

        // sw killed in EX, with a simultaneously killed R-type in ID
        drive(6'b101011, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sw ex_mem_write", 32'(ex_mem_write), 1);
        drive(6'b000000, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("kill_ex mem_mem_write", 32'(mem_mem_write), 0);
        chk("kill_ex mem_valid", 32'(mem_valid), 0);
        chk("kill_id ex_valid", 32'(ex_valid), 0);
        drive(6'b101011, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        valid_id = 1'b0;
        tick();
        chk("sw mem_mem_write", 32'(mem_mem_write), 1);
        chk("sw mem_valid", 32'(mem_valid), 1);

        // Saturation on the CNT_W=2 instance
        rst_n = 1'b0;
        drive(6'b001000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] exp_sat [5] = '{1, 2, 3, 3, 3};
            tick();
            chk($sformatf("sat cycle%0d s_bubble_cnt", i + 1), 32'(s_bubble_cnt), exp_sat[i]);
        end
        chk("sat wide bubble_cnt", 32'(bubble_cnt), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
